// File: rtl/gem_cluster_pkg.sv
// Shared types and constants for the GEM cluster frame builder: cluster layout,
// validity limits and the frame FSM state encoding.
package gem_cluster_pkg;

  localparam int NUM_CLUSTERS = 8;
  localparam int ADR_W        = 11;
  localparam int CNT_W        = 3;
  localparam int CLUSTER_W    = 14;
  localparam int NVALID_W     = 4;

  localparam logic [ADR_W-1:0] MAX_VALID_ADR = 11'd1535;
  localparam logic [ADR_W-1:0] INVALID_ADR   = 11'h7FF;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [ADR_W-1:0] adr;
  } cluster_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam cluster_t INVALID_CLUSTER = '{cnt: 3'd0, adr: INVALID_ADR};

endpackage

// File: rtl/cluster_sanitize.sv
// Combinational validity check for one cluster; out-of-range addresses are
// replaced by the canonical empty cluster {cnt=0, adr=7FF}.
module cluster_sanitize
  import gem_cluster_pkg::*;
(
  input  logic [CLUSTER_W-1:0] cluster_in,
  output cluster_t             cluster_out,
  output logic                 valid
);

  cluster_t raw;

  assign raw         = cluster_t'(cluster_in);
  assign valid       = (raw.adr <= MAX_VALID_ADR);
  assign cluster_out = valid ? raw : INVALID_CLUSTER;

endmodule

// File: rtl/cluster_frame_builder.sv
// Captures 8 clusters per BX strobe and serialises them as four 28-bit slots
// on the 160 MHz clock, flagging strobes that arrive before the frame ends.
module cluster_frame_builder
  import gem_cluster_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                              clock4x,
  input  logic                              global_reset_n,
  input  logic                              bx_strobe_in,
  input  logic [NUM_CLUSTERS*CLUSTER_W-1:0] clusters_in,
  input  logic                              cnt_reset,
  output logic [2*CLUSTER_W-1:0]            frame_word,
  output logic                              frame_valid,
  output logic                              frame_start,
  output logic [NVALID_W-1:0]               frame_nvalid,
  output logic                              align_err,
  output logic [COUNT_W-1:0]                valid_cluster_cnt,
  output state_e                            dbg_state,
  output logic [1:0]                        dbg_slot
);

  cluster_t [NUM_CLUSTERS-1:0] san;
  logic     [NUM_CLUSTERS-1:0] san_valid;
  logic     [NVALID_W-1:0]     cap_nvalid;

  for (genvar k = 0; k < NUM_CLUSTERS; k++) begin : g_san
    cluster_sanitize u_san (
      .cluster_in  (clusters_in[k*CLUSTER_W +: CLUSTER_W]),
      .cluster_out (san[k]),
      .valid       (san_valid[k])
    );
  end

  always_comb begin
    cap_nvalid = '0;
    for (int k = 0; k < NUM_CLUSTERS; k++) begin
      cap_nvalid = cap_nvalid + NVALID_W'(san_valid[k]);
    end
  end

  state_e                      state_q, state_d;
  logic [1:0]                  slot_q, slot_d;
  cluster_t [NUM_CLUSTERS-1:0] hold_q, hold_d;
  logic [NVALID_W-1:0]         hold_nv_q, hold_nv_d;
  logic [2*CLUSTER_W-1:0]      word_q, word_d;
  logic                        valid_q, valid_d;
  logic                        start_q, start_d;
  logic [NVALID_W-1:0]         nv_q, nv_d;
  logic                        align_q, align_d;
  logic [COUNT_W-1:0]          cnt_q, cnt_d;
  logic [COUNT_W:0]            cnt_sum;

  // Outputs are derived from the next state so slot 0 leaves one edge after the strobe.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    hold_d    = hold_q;
    hold_nv_d = hold_nv_q;
    align_d   = 1'b0;
    if (bx_strobe_in) begin
      state_d   = SEND;
      slot_d    = 2'd0;
      hold_d    = san;
      hold_nv_d = cap_nvalid;
      align_d   = (state_q == SEND) && (slot_q != 2'd3);
    end else if (state_q == SEND) begin
      if (slot_q == 2'd3) begin
        state_d = IDLE;
        slot_d  = 2'd0;
      end else begin
        slot_d = slot_q + 2'd1;
      end
    end

    word_d  = '0;
    valid_d = 1'b0;
    start_d = 1'b0;
    nv_d    = '0;
    if (state_d == SEND) begin
      word_d  = {hold_d[{slot_d, 1'b1}], hold_d[{slot_d, 1'b0}]};
      valid_d = 1'b1;
      start_d = (slot_d == 2'd0);
      nv_d    = hold_nv_d;
    end
  end

  // Saturating accumulate; a coincident clear discards the capture.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (COUNT_W+1)'(cap_nvalid);
    cnt_d   = cnt_q;
    if (cnt_reset) begin
      cnt_d = '0;
    end else if (bx_strobe_in) begin
      cnt_d = cnt_sum[COUNT_W] ? {COUNT_W{1'b1}} : cnt_sum[COUNT_W-1:0];
    end
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q   <= IDLE;
      slot_q    <= 2'd0;
      hold_q    <= {NUM_CLUSTERS{INVALID_CLUSTER}};
      hold_nv_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      nv_q      <= '0;
      align_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      hold_q    <= hold_d;
      hold_nv_q <= hold_nv_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      nv_q      <= nv_d;
      align_q   <= align_d;
      cnt_q     <= cnt_d;
    end
  end

  assign frame_word        = word_q;
  assign frame_valid       = valid_q;
  assign frame_start       = start_q;
  assign frame_nvalid      = nv_q;
  assign align_err         = align_q;
  assign valid_cluster_cnt = cnt_q;
  assign dbg_state         = state_q;
  assign dbg_slot          = slot_q;

endmodule

// File: tb/tb_cluster_frame_builder.sv
// Bench for cluster_frame_builder: queue-based frame model checked every cycle,
// directed frames with literal expectations, then randomized strobes and clusters.
module tb_cluster_frame_builder;
  import gem_cluster_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #3 clk = ~clk;

  logic          strobe = 1'b0;
  logic          cnt_reset = 1'b0;
  logic [111:0]  clusters = '0;
  logic [27:0]   frame_word;
  logic          frame_valid, frame_start, align_err;
  logic [3:0]    frame_nvalid;
  logic [CW-1:0] vcnt;
  state_e        dbg_state;
  logic [1:0]    dbg_slot;

  cluster_frame_builder #(.COUNT_W(CW)) dut (
    .clock4x           (clk),
    .global_reset_n    (rst_n),
    .bx_strobe_in      (strobe),
    .clusters_in       (clusters),
    .cnt_reset         (cnt_reset),
    .frame_word        (frame_word),
    .frame_valid       (frame_valid),
    .frame_start       (frame_start),
    .frame_nvalid      (frame_nvalid),
    .align_err         (align_err),
    .valid_cluster_cnt (vcnt),
    .dbg_state         (dbg_state),
    .dbg_slot          (dbg_slot)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // exp_q holds the slot words still to be shown after the current one.
  logic [27:0] exp_q[$];
  logic [27:0] m_word = '0;
  logic        m_valid = 1'b0, m_start = 1'b0, m_align = 1'b0;
  int          m_nv = 0, m_hold_nv = 0, m_cnt = 0, m_n = 0;
  logic [13:0] m_c[8];

  function automatic logic [13:0] norm(input logic [13:0] c);
    if (int'(c[10:0]) <= 1535) return c;
    return 14'h07FF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_word = '0; m_valid = 1'b0; m_start = 1'b0; m_align = 1'b0;
      m_nv = 0; m_hold_nv = 0; m_cnt = 0;
    end else begin
      m_start = strobe;
      m_align = 1'b0;
      if (strobe) begin
        m_align = (exp_q.size() > 0);
        exp_q.delete();
        m_n = 0;
        for (int k = 0; k < 8; k++) begin
          m_c[k] = norm(clusters[14*k +: 14]);
          if (int'(clusters[14*k +: 11]) <= 1535) m_n++;
        end
        for (int s = 0; s < 4; s++) exp_q.push_back({m_c[2*s+1], m_c[2*s]});
        m_hold_nv = m_n;
        if (cnt_reset) m_cnt = 0;
        else m_cnt = (m_cnt + m_n > CMAX) ? CMAX : m_cnt + m_n;
      end else if (cnt_reset) begin
        m_cnt = 0;
      end
      if (exp_q.size() > 0) begin
        m_word = exp_q.pop_front(); m_valid = 1'b1; m_nv = m_hold_nv;
      end else begin
        m_word = '0; m_valid = 1'b0; m_nv = 0;
      end
      #1;
      check("frame_valid", frame_valid, m_valid);
      check("frame_start", frame_start, m_start);
      check("frame_word", frame_word, m_word);
      check("frame_nvalid", frame_nvalid, m_nv);
      check("align_err", align_err, m_align);
      check("valid_cluster_cnt", vcnt, m_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bx(input logic [111:0] c, input logic cr);
    strobe = 1'b1; clusters = c; cnt_reset = cr;
    @(negedge clk);
    strobe = 1'b0; cnt_reset = 1'b0;
  endtask

  // Called right after drive_bx; ends at the negedge where slot 3 is visible.
  task automatic frame_checks(input string tag, input logic [27:0] s0, input logic [27:0] s1,
                              input int nv, input int cnt);
    check({tag, "_s0"}, frame_word, s0);
    check({tag, "_start"}, frame_start, 1'b1);
    check({tag, "_nvalid"}, frame_nvalid, nv);
    check({tag, "_cnt"}, vcnt, cnt);
    @(negedge clk);
    check({tag, "_s1"}, frame_word, s1);
    check({tag, "_nvalid_s1"}, frame_nvalid, nv);
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [111:0] p29, p30;

  initial begin
    for (int k = 0; k < 8; k++) begin
      p29[14*k +: 14] = {3'(k), 11'(k * 100)};
      p30[14*k +: 14] = {3'(k), ((k % 2) == 1) ? 11'd1536 : 11'd2047};
    end
    p30[0 +: 14]  = {3'd0, 11'd5};
    p30[14 +: 14] = {3'd1, 11'd600};
    p30[28 +: 14] = {3'd2, 11'd1535};

    repeat (3) @(negedge clk);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_word", frame_word, 28'h0);
    check("rst_nvalid", frame_nvalid, 4'h0);
    check("rst_align", align_err, 1'b0);
    check("rst_cnt", vcnt, 4'h0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Gapless frames, counter 0 -> 8 -> saturated 15
    drive_bx(p29, 1'b0);
    frame_checks("p29a", {14'h0864, 14'h0000}, {14'h192C, 14'h10C8}, 8, 8);
    check("p29a_s3", frame_word, {14'h3ABC, 14'h3258});
    drive_bx(p29, 1'b0);
    frame_checks("p29b", {14'h0864, 14'h0000}, {14'h192C, 14'h10C8}, 8, 15);
    @(negedge clk);
    check("single_tail_valid", frame_valid, 1'b0);
    check("single_tail_word", frame_word, 28'h0);

    // Clear counter, then four 3-valid frames reach 12; a capture of 8 saturates
    cnt_reset = 1'b1;
    @(negedge clk);
    cnt_reset = 1'b0;
    check("cnt_cleared", vcnt, 4'h0);
    for (int i = 0; i < 4; i++) begin
      drive_bx(p30, 1'b0);
      frame_checks("p30", {14'h0A58, 14'h0005}, {14'h07FF, 14'h15FF}, 3, 3 * (i + 1));
    end
    drive_bx(p29, 1'b0);
    check("sat_12_plus_8", vcnt, 4'd15);
    @(negedge clk);
    @(negedge clk);
    drive_bx(p29, 1'b1);
    check("clear_wins", vcnt, 4'd0);
    repeat (4) @(negedge clk);

    // Strobes two cycles apart
    drive_bx(p29, 1'b0);
    check("first_no_align", align_err, 1'b0);
    @(negedge clk);
    drive_bx(p30, 1'b0);
    check("abort_align", align_err, 1'b1);
    check("abort_start", frame_start, 1'b1);
    check("abort_s0", frame_word, {14'h0A58, 14'h0005});
    @(negedge clk);
    check("align_one_cycle", align_err, 1'b0);
    check("abort_s1", frame_word, {14'h07FF, 14'h15FF});
    @(negedge clk);

    // Asynchronous reset at slot 2
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", frame_valid, 1'b0);
    check("arst_word", frame_word, 28'h0);
    check("arst_nvalid", frame_nvalid, 4'h0);
    check("arst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", frame_valid, 1'b0);
    drive_bx(p29, 1'b0);
    check("post_rst_align", align_err, 1'b0);
    check("post_rst_start", frame_start, 1'b1);
    repeat (4) @(negedge clk);

    // Randomized strobes, clusters and clears
    for (int i = 0; i < 400; i++) begin
      strobe = ($urandom_range(0, 3) == 0);
      cnt_reset = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 8; k++) clusters[14*k +: 14] = 14'($urandom_range(0, 16383));
      @(negedge clk);
    end
    strobe = 1'b0;
    cnt_reset = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cluster_frame_builder.md
CLUSTER_FRAME_BUILDER -- requirements
Module: cluster_frame_builder

Interface
REQ-001 Parameter COUNT_W, default 16, width of the valid-cluster counter.
REQ-002 clock4x  in  1  160 MHz clock; the block's only clock.
REQ-003 global_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 bx_strobe_in  in  1  one-cycle pulse per 40 MHz BX; qualifies clusters_in.
REQ-005 clusters_in  in  112  8 clusters, cluster k = bits [14k+13:14k] = {cnt[2:0], adr[10:0]}.
REQ-006 cnt_reset  in  1  synchronous clear of valid_cluster_cnt.
REQ-007 frame_word  out  28  slot payload {cluster 2s+1, cluster 2s} for slot s.
REQ-008 frame_valid  out  1  frame_word carries a slot.
REQ-009 frame_start  out  1  high with slot 0.
REQ-010 frame_nvalid  out  4  number of valid clusters (0..8) in the frame being sent.
REQ-011 align_err  out  1  one-cycle pulse on a misaligned strobe.
REQ-012 valid_cluster_cnt  out  COUNT_W  saturating total of valid clusters.

Function
REQ-013 A cluster SHALL be valid when adr <= 1535; otherwise it SHALL be normalized to adr=11'h7FF, cnt=3'd0 before capture.
REQ-014 On a clock4x edge with bx_strobe_in=1, the block SHALL capture all 8 normalized clusters and their valid count in one holding register.
REQ-015 FSM states SHALL be IDLE and SEND; SEND SHALL carry a 2-bit slot counter.
REQ-016 A capture SHALL enter SEND with slot=0; outputs SHALL be registered, so slot 0 appears in the cycle after the strobe edge (latency 1).
REQ-017 In SEND without a strobe, slot SHALL increment 0->1->2->3, and frame_word SHALL show clusters {2s+1, 2s}.
REQ-018 A strobe while slot=3 SHALL be the aligned case: capture and restart at slot 0, so back-to-back frames are gapless.
REQ-019 After slot 3 without a strobe, the FSM SHALL return to IDLE, and frame_valid, frame_start, frame_word and frame_nvalid SHALL be 0.
REQ-020 A strobe while in SEND with slot 0..2 SHALL abort the current frame, capture the new clusters, restart at slot 0 and pulse align_err for one cycle, coincident with the new slot 0.
REQ-021 A strobe in IDLE SHALL capture without align_err.
REQ-022 frame_nvalid SHALL hold the captured count for all 4 slots of a frame.
REQ-023 valid_cluster_cnt SHALL add the count at each capture and saturate at 2^COUNT_W-1 (no wrap).
REQ-024 cnt_reset SHALL clear valid_cluster_cnt to 0 on the next edge; when it coincides with a capture, the counter SHALL be 0 (clear wins, that capture's count is discarded).

Reset
REQ-025 global_reset_n=0 SHALL immediately force the following, regardless of the clock:
- state to IDLE, slot to 0;
- the holding register to all-invalid clusters;
- every output to 0.
REQ-026 Reset asserted mid-frame SHALL drop the frame; after release, output SHALL resume only at the next strobe.

Structure
REQ-027 A shared package gem_cluster_pkg SHALL hold:
- NUM_CLUSTERS=8, ADR_W=11, CNT_W=3, CLUSTER_W=14;
- MAX_VALID_ADR=1535, INVALID_ADR=11'h7FF;
- the cluster struct {cnt, adr} and the FSM state enum.
REQ-028 One sub-module, cluster_sanitize (combinational, one instance per cluster), SHALL do validity check and normalization.

Verification
REQ-029 Strobe every 4 cycles; clusters 0..7 with adr=k*100, cnt=k ->
- slots 0..3 show pairs (1,0), (3,2), (5,4), (7,6) gaplessly;
- frame_start on each slot 0; frame_nvalid=8;
- counter +8 per BX.
REQ-030 Clusters 0..2 with adr=5, 600, 1535, rest adr=1536/2047 ->
- clusters 3..7 output as {0, 7FF};
- frame_nvalid=3; counter +3.
REQ-031 Single strobe, then none ->
- 4 valid slots, then frame_valid=0 and frame_word=0 from the 5th cycle on.
REQ-032 Strobes 2 cycles apart ->
- align_err pulses once with the new slot 0;
- first frame stops after slot 1; second frame sends all 4 slots.
REQ-033 Counter preset near full (COUNT_W=4, at 12), capture of 8 ->
- counter reads 15 (saturated), not 4.
- cnt_reset with a simultaneous capture -> counter reads 0.
REQ-034 Reset asserted at slot 2 ->
- outputs go to 0 immediately;
- after release, with no strobe, frame_valid stays 0;
- the next strobe restarts at slot 0 with no align_err.
